// File: rtl/pmem_arbiter.sv
// pmem_arbiter: shares one 256-bit physical-memory port between the L1 I-cache and the L1 D-cache.
// Optional round-robin tie-break between the two caches: define PMEM_ARB_RR_EN.
module pmem_arbiter #(
    parameter int S_LINE = 256,
    parameter int S_ADDR = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_pmem_read,
    input  logic [S_ADDR-1:0] i_pmem_address,
    output logic [S_LINE-1:0] i_pmem_rdata,
    output logic              i_pmem_resp,
    input  logic              d_pmem_read,
    input  logic              d_pmem_write,
    input  logic [S_ADDR-1:0] d_pmem_address,
    input  logic [S_LINE-1:0] d_pmem_wdata,
    output logic [S_LINE-1:0] d_pmem_rdata,
    output logic              d_pmem_resp,
    output logic              pmem_read,
    output logic              pmem_write,
    output logic [S_ADDR-1:0] pmem_address,
    output logic [S_LINE-1:0] pmem_wdata,
    input  logic [S_LINE-1:0] pmem_rdata,
    input  logic              pmem_resp
);

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_GRANT_I = 3'd1,
        ST_GRANT_D = 3'd2,
        ST_RESP_I  = 3'd3,
        ST_RESP_D  = 3'd4
    } state_t;

    state_t              state_q, state_d;
    logic                req_read_q, req_read_d;
    logic                req_write_q, req_write_d;
    logic [S_ADDR-1:0]   req_addr_q, req_addr_d;
    logic [S_LINE-1:0]   req_wdata_q, req_wdata_d;
    logic [S_LINE-1:0]   line_buf_q, line_buf_d;
    logic                i_resp_q, i_resp_d;
    logic                d_resp_q, d_resp_d;
    logic                i_req_s, d_req_s;
    logic                grant_i_s, grant_d_s;
`ifdef PMEM_ARB_RR_EN
    logic                last_d_q, last_d_d;
`endif

    // Winner selection; only consulted while idle.
    always_comb begin
        i_req_s = i_pmem_read;
        d_req_s = d_pmem_read | d_pmem_write;
`ifdef PMEM_ARB_RR_EN
        grant_d_s = d_req_s & (~i_req_s | ~last_d_q);
`else
        grant_d_s = d_req_s;
`endif
        grant_i_s = i_req_s & ~grant_d_s;
    end

    // Next-state and next-register values for the transaction sequencer.
    always_comb begin
        state_d     = state_q;
        req_read_d  = req_read_q;
        req_write_d = req_write_q;
        req_addr_d  = req_addr_q;
        req_wdata_d = req_wdata_q;
        line_buf_d  = line_buf_q;
        i_resp_d    = 1'b0;
        d_resp_d    = 1'b0;
`ifdef PMEM_ARB_RR_EN
        last_d_d    = last_d_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (grant_d_s) begin
                    // Both D flags high is a write-back.
                    state_d     = ST_GRANT_D;
                    req_read_d  = ~d_pmem_write;
                    req_write_d = d_pmem_write;
                    req_addr_d  = d_pmem_address;
                    req_wdata_d = d_pmem_wdata;
`ifdef PMEM_ARB_RR_EN
                    last_d_d    = 1'b1;
`endif
                end else if (grant_i_s) begin
                    state_d     = ST_GRANT_I;
                    req_read_d  = 1'b1;
                    req_write_d = 1'b0;
                    req_addr_d  = i_pmem_address;
                    req_wdata_d = {S_LINE{1'b0}};
`ifdef PMEM_ARB_RR_EN
                    last_d_d    = 1'b0;
`endif
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_GRANT_I: begin
                if (pmem_resp) begin
                    state_d     = ST_RESP_I;
                    line_buf_d  = pmem_rdata;
                    req_read_d  = 1'b0;
                    req_write_d = 1'b0;
                    i_resp_d    = 1'b1;
                end else begin
                    state_d = ST_GRANT_I;
                end
            end
            ST_GRANT_D: begin
                if (pmem_resp) begin
                    state_d     = ST_RESP_D;
                    line_buf_d  = pmem_rdata;
                    req_read_d  = 1'b0;
                    req_write_d = 1'b0;
                    d_resp_d    = 1'b1;
                end else begin
                    state_d = ST_GRANT_D;
                end
            end
            ST_RESP_I: begin
                state_d = ST_IDLE;
            end
            ST_RESP_D: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d     = ST_IDLE;
                req_read_d  = 1'b0;
                req_write_d = 1'b0;
            end
        endcase
    end

    // State and datapath registers; reset abandons any in-flight command.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            req_read_q  <= 1'b0;
            req_write_q <= 1'b0;
            req_addr_q  <= {S_ADDR{1'b0}};
            req_wdata_q <= {S_LINE{1'b0}};
            line_buf_q  <= {S_LINE{1'b0}};
            i_resp_q    <= 1'b0;
            d_resp_q    <= 1'b0;
`ifdef PMEM_ARB_RR_EN
            last_d_q    <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            req_read_q  <= req_read_d;
            req_write_q <= req_write_d;
            req_addr_q  <= req_addr_d;
            req_wdata_q <= req_wdata_d;
            line_buf_q  <= line_buf_d;
            i_resp_q    <= i_resp_d;
            d_resp_q    <= d_resp_d;
`ifdef PMEM_ARB_RR_EN
            last_d_q    <= last_d_d;
`endif
        end
    end

    assign pmem_read    = req_read_q;
    assign pmem_write   = req_write_q;
    assign pmem_address = req_addr_q;
    assign pmem_wdata   = req_wdata_q;
    assign i_pmem_rdata = line_buf_q;
    assign d_pmem_rdata = line_buf_q;
    assign i_pmem_resp  = i_resp_q;
    assign d_pmem_resp  = d_resp_q;

endmodule

// File: tb/tb_pmem_arbiter.sv
// Self-checking bench for pmem_arbiter: directed scenarios, then randomized traffic
// checked against a cycle-timestamp reference model of the arbitration rules.
module tb_pmem_arbiter;
    localparam int L = 256;
    localparam int A = 32;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          i_pmem_read;
    logic [A-1:0]  i_pmem_address;
    logic [L-1:0]  i_pmem_rdata;
    logic          i_pmem_resp;
    logic          d_pmem_read;
    logic          d_pmem_write;
    logic [A-1:0]  d_pmem_address;
    logic [L-1:0]  d_pmem_wdata;
    logic [L-1:0]  d_pmem_rdata;
    logic          d_pmem_resp;
    logic          pmem_read;
    logic          pmem_write;
    logic [A-1:0]  pmem_address;
    logic [L-1:0]  pmem_wdata;
    logic [L-1:0]  pmem_rdata;
    logic          pmem_resp;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    pmem_arbiter #(.S_LINE(L), .S_ADDR(A)) dut (
        .clk(clk), .rst_n(rst_n),
        .i_pmem_read(i_pmem_read), .i_pmem_address(i_pmem_address),
        .i_pmem_rdata(i_pmem_rdata), .i_pmem_resp(i_pmem_resp),
        .d_pmem_read(d_pmem_read), .d_pmem_write(d_pmem_write),
        .d_pmem_address(d_pmem_address), .d_pmem_wdata(d_pmem_wdata),
        .d_pmem_rdata(d_pmem_rdata), .d_pmem_resp(d_pmem_resp),
        .pmem_read(pmem_read), .pmem_write(pmem_write),
        .pmem_address(pmem_address), .pmem_wdata(pmem_wdata),
        .pmem_rdata(pmem_rdata), .pmem_resp(pmem_resp)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [L-1:0] obs, input logic [L-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [L-1:0] rand_line();
        logic [L-1:0] r;
        for (int i = 0; i < 8; i++) r[i*32 +: 32] = $urandom;
        return r;
    endfunction

    task automatic drive_i(input logic [A-1:0] addr);
        i_pmem_read    = 1'b1;
        i_pmem_address = addr;
    endtask

    task automatic drive_d(input bit rd, input bit wr, input logic [A-1:0] addr, input logic [L-1:0] wd);
        d_pmem_read    = rd;
        d_pmem_write   = wr;
        d_pmem_address = addr;
        d_pmem_wdata   = wd;
    endtask

    // Called in the first command cycle; memory answers in cycle 'lat'; returns in the idle cycle.
    task automatic expect_txn(input bit is_d, input bit wr, input logic [A-1:0] addr,
                              input logic [L-1:0] wd, input int lat, input logic [L-1:0] rd,
                              input string tag);
        for (int c = 1; c <= lat; c++) begin
            check({tag, ".cmd_rd"}, pmem_read, !wr);
            check({tag, ".cmd_wr"}, pmem_write, wr);
            check({tag, ".addr"}, pmem_address, addr);
            if (wr) check({tag, ".wdata"}, pmem_wdata, wd);
            check({tag, ".iresp_early"}, i_pmem_resp, 1'b0);
            check({tag, ".dresp_early"}, d_pmem_resp, 1'b0);
            pmem_resp  = (c == lat);
            pmem_rdata = (c == lat) ? rd : rand_line();
            tick();
        end
        pmem_resp = 1'b0;
        check({tag, ".resp_cmd_rd"}, pmem_read, 1'b0);
        check({tag, ".resp_cmd_wr"}, pmem_write, 1'b0);
        check({tag, ".own_resp"}, is_d ? d_pmem_resp : i_pmem_resp, 1'b1);
        check({tag, ".other_resp"}, is_d ? i_pmem_resp : d_pmem_resp, 1'b0);
        check({tag, ".rdata"}, is_d ? d_pmem_rdata : i_pmem_rdata, rd);
        tick();
        if (is_d) begin
            d_pmem_read  = 1'b0;
            d_pmem_write = 1'b0;
        end else begin
            i_pmem_read = 1'b0;
        end
        check({tag, ".idle_iresp"}, i_pmem_resp, 1'b0);
        check({tag, ".idle_dresp"}, d_pmem_resp, 1'b0);
        check({tag, ".idle_rd"}, pmem_read, 1'b0);
        check({tag, ".idle_wr"}, pmem_write, 1'b0);
    endtask

    // Reference-model state for the random phase.
    int           cyc, owner, mresp, free_cyc;
    bit           p_i, p_d, p_dw, win_d, e_rd, e_wr, e_ir, e_dr, i_drop, d_drop, first_d, last_d_m;
    logic [A-1:0] p_ia, p_da, e_addr;
    logic [L-1:0] p_dwd, e_wdata, mdata, m_line, tmp_line;
    int           kind;

    initial begin
        rst_n = 1'b0;
        i_pmem_read = 1'b0; i_pmem_address = '0;
        d_pmem_read = 1'b0; d_pmem_write = 1'b0; d_pmem_address = '0; d_pmem_wdata = '0;
        pmem_rdata = '0; pmem_resp = 1'b0;
        tick(); tick();
        check("rst.pmem_read", pmem_read, 1'b0);
        check("rst.pmem_write", pmem_write, 1'b0);
        check("rst.pmem_address", pmem_address, '0);
        check("rst.pmem_wdata", pmem_wdata, '0);
        check("rst.i_resp", i_pmem_resp, 1'b0);
        check("rst.d_resp", d_pmem_resp, 1'b0);
        check("rst.i_rdata", i_pmem_rdata, '0);
        check("rst.d_rdata", d_pmem_rdata, '0);
        rst_n = 1'b1;
        tick();

        // I-only read, memory answers after 5 cycles.
        tmp_line = {32{8'hAA}};
        drive_i(32'h0000_0040);
        tick();
        expect_txn(1'b0, 1'b0, 32'h0000_0040, '0, 5, tmp_line, "t1_iread");

        // D write-back.
        drive_d(1'b0, 1'b1, 32'h0000_1000, {32{8'h55}});
        tick();
        expect_txn(1'b1, 1'b1, 32'h0000_1000, {32{8'h55}}, 4, rand_line(), "t2_dwrite");

        // Simultaneous I and D reads; previous grant went to D.
`ifdef PMEM_ARB_RR_EN
        first_d = 1'b0;
`else
        first_d = 1'b1;
`endif
        drive_i(32'h0000_0080);
        drive_d(1'b1, 1'b0, 32'h0000_2000, '0);
        tick();
        if (first_d) begin
            expect_txn(1'b1, 1'b0, 32'h0000_2000, '0, 2, rand_line(), "t3_first_d");
            tick();
            expect_txn(1'b0, 1'b0, 32'h0000_0080, '0, 3, rand_line(), "t3_second_i");
        end else begin
            expect_txn(1'b0, 1'b0, 32'h0000_0080, '0, 2, rand_line(), "t3_first_i");
            tick();
            expect_txn(1'b1, 1'b0, 32'h0000_2000, '0, 3, rand_line(), "t3_second_d");
        end

        // D request arrives while I is already granted.
        drive_i(32'h0000_00C0);
        tick();
        drive_d(1'b1, 1'b0, 32'h0000_3000, '0);
        expect_txn(1'b0, 1'b0, 32'h0000_00C0, '0, 4, rand_line(), "t4_i_held");
        tick();
        expect_txn(1'b1, 1'b0, 32'h0000_3000, '0, 2, rand_line(), "t4_d_after");

        // Reset two cycles into a D read.
        drive_d(1'b1, 1'b0, 32'h0000_4000, '0);
        tick();
        check("t5.cmd_before_rst", pmem_read, 1'b1);
        tick();
        rst_n = 1'b0;
        #1;
        check("t5.rst_pmem_read", pmem_read, 1'b0);
        check("t5.rst_pmem_write", pmem_write, 1'b0);
        check("t5.rst_pmem_address", pmem_address, '0);
        check("t5.rst_pmem_wdata", pmem_wdata, '0);
        check("t5.rst_i_resp", i_pmem_resp, 1'b0);
        check("t5.rst_d_resp", d_pmem_resp, 1'b0);
        check("t5.rst_i_rdata", i_pmem_rdata, '0);
        check("t5.rst_d_rdata", d_pmem_rdata, '0);
        d_pmem_read = 1'b0;
        pmem_resp = 1'b1;
        tick();
        check("t5.held_d_resp", d_pmem_resp, 1'b0);
        pmem_resp = 1'b0;
        rst_n = 1'b1;
        tick();
        check("t5.post_d_resp", d_pmem_resp, 1'b0);
        check("t5.post_pmem_read", pmem_read, 1'b0);
        drive_i(32'h0000_0500);
        tick();
        expect_txn(1'b0, 1'b0, 32'h0000_0500, '0, 2, rand_line(), "t5_fresh_i");

        // Back-to-back D reads against single-cycle memory.
        for (int k = 0; k < 3; k++) begin
            drive_d(1'b1, 1'b0, 32'h0000_6000 + 32'(k * 32), '0);
            tick();
            expect_txn(1'b1, 1'b0, 32'h0000_6000 + 32'(k * 32), '0, 1, rand_line(), "t6_b2b");
        end

        // Random traffic against the reference model.
        rst_n = 1'b0;
        i_pmem_read = 1'b0; d_pmem_read = 1'b0; d_pmem_write = 1'b0; pmem_resp = 1'b0;
        tick();
        rst_n = 1'b1;
        cyc = 0; owner = 0; mresp = 0; free_cyc = 0; last_d_m = 1'b0;
        m_line = '0; i_drop = 1'b0; d_drop = 1'b0;
        e_rd = 1'b0; e_wr = 1'b0; e_addr = '0; e_wdata = '0; mdata = '0;
        for (int n = 0; n < 3000; n++) begin
            p_i = i_pmem_read; p_ia = i_pmem_address;
            p_d = d_pmem_read | d_pmem_write; p_dw = d_pmem_write;
            p_da = d_pmem_address; p_dwd = d_pmem_wdata;
            tick();
            cyc++;
            e_ir = 1'b0; e_dr = 1'b0;
            if (owner == 0 && cyc - 1 >= free_cyc && (p_i || p_d)) begin
`ifdef PMEM_ARB_RR_EN
                win_d = p_d && (!p_i || !last_d_m);
                last_d_m = win_d;
`else
                win_d = p_d;
`endif
                owner   = win_d ? 2 : 1;
                e_rd    = win_d ? !p_dw : 1'b1;
                e_wr    = win_d ? p_dw : 1'b0;
                e_addr  = win_d ? p_da : p_ia;
                e_wdata = p_dwd;
                mresp   = cyc + int'($urandom_range(0, 3));
                mdata   = rand_line();
            end
            if (owner != 0 && cyc <= mresp) begin
                check("rnd.cmd_rd", pmem_read, e_rd);
                check("rnd.cmd_wr", pmem_write, e_wr);
                check("rnd.addr", pmem_address, e_addr);
                if (e_wr) check("rnd.wdata", pmem_wdata, e_wdata);
                pmem_resp  = (cyc == mresp);
                pmem_rdata = (cyc == mresp) ? mdata : rand_line();
            end else begin
                if (owner != 0) begin
                    m_line   = mdata;
                    e_ir     = (owner == 1);
                    e_dr     = (owner == 2);
                    owner    = 0;
                    free_cyc = cyc + 1;
                end
                check("rnd.idle_rd", pmem_read, 1'b0);
                check("rnd.idle_wr", pmem_write, 1'b0);
                pmem_resp  = ($urandom_range(0, 3) == 0);
                pmem_rdata = rand_line();
            end
            check("rnd.i_resp", i_pmem_resp, e_ir);
            check("rnd.d_resp", d_pmem_resp, e_dr);
            check("rnd.i_rdata", i_pmem_rdata, m_line);
            check("rnd.d_rdata", d_pmem_rdata, m_line);
            if (e_ir) begin
                i_drop = 1'b1;
            end else if (i_drop) begin
                i_pmem_read = 1'b0;
                i_drop = 1'b0;
            end else if (!i_pmem_read && $urandom_range(0, 2) == 0) begin
                drive_i($urandom & 32'hFFFF_FFE0);
            end
            if (e_dr) begin
                d_drop = 1'b1;
            end else if (d_drop) begin
                d_pmem_read = 1'b0;
                d_pmem_write = 1'b0;
                d_drop = 1'b0;
            end else if (!(d_pmem_read || d_pmem_write) && $urandom_range(0, 2) == 0) begin
                kind = int'($urandom_range(0, 2));
                drive_d(kind != 1, kind != 0, $urandom & 32'hFFFF_FFE0, rand_line());
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
